// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART scheduler definitions: frame geometry defaults, parity codes and FSM encodings.
// The same constants are used by tx and the receiver so all ends agree on line timing.
package uart_tx_scheduler_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_DATA_BITS      = 8;
  localparam int unsigned DEF_COUNTS_PER_BIT = 434;
  localparam int unsigned DEF_FRAME_BITS     = 11;
  localparam int unsigned DEF_GAP_BITS       = 1;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_t;

  // Cycles one launch occupies the line: frame plus trailing idle gap.
  function automatic int unsigned frame_len(input int unsigned counts_per_bit,
                                            input int unsigned frame_bits,
                                            input int unsigned gap_bits);
    return (frame_bits + gap_bits) * counts_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
// The pointer register itself lives in the scheduler.
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);

  int unsigned j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// tx has no busy flag, so a local frame timer paces launches one frame (+gap) apart.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
  parameter int unsigned COUNTS_PER_BIT = DEF_COUNTS_PER_BIT,
  parameter int unsigned FRAME_BITS     = DEF_FRAME_BITS,
  parameter int unsigned GAP_BITS       = DEF_GAP_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data_in,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_send,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int unsigned L  = frame_len(COUNTS_PER_BIT, FRAME_BITS, GAP_BITS);
  localparam int unsigned TW = $clog2(L);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [TW-1:0] TIMER_LAST = TW'(L - 1);

  sched_state_t state;
  logic [TW-1:0] timer;
  logic [IW-1:0] ptr;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [IW-1:0]        win_idx;
  logic                 win_valid;
  logic [DATA_BITS-1:0] win_byte;
  logic [IW-1:0]        ptr_next;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_byte = data_in[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Explicit wrap keeps the modulo correct when NUM_REQ is not a power of two.
  assign ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      ptr      <= '0;
      ack      <= '0;
      tx_data  <= '0;
      tx_send  <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack     <= '0;
          tx_send <= 1'b0;
          busy    <= 1'b0;
          if (win_valid) begin
            tx_data  <= win_byte;
            ack      <= win_onehot;
            tx_send  <= 1'b1;
            grant_id <= win_idx;
            busy     <= 1'b1;
            timer    <= '0;
            ptr      <= ptr_next;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          ack     <= '0;
          tx_send <= 1'b0;
          if (timer == TIMER_LAST) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with COUNTS_PER_BIT=4, NUM_REQ=4 (L=48).
module tb_uart_tx_scheduler;

  localparam int NR  = 4;
  localparam int DB  = 8;
  localparam int L   = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DB-1:0]  data_in;
  logic [NR-1:0]     ack;
  logic [DB-1:0]     tx_data;
  logic              tx_send;
  logic [1:0]        grant_id;
  logic              busy;

  typedef struct {
    int        id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   launch_cnt = 0;
  logic [7:0] last_data = '0;

  uart_tx_scheduler #(
    .NUM_REQ        (NR),
    .DATA_BITS      (DB),
    .COUNTS_PER_BIT (4),
    .FRAME_BITS     (11),
    .GAP_BITS       (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: every launch is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      last_data = '0;
    end else begin
      if (tx_send || (ack != '0))
        check("ack_with_send", {31'b0, tx_send}, {31'b0, |ack});
      if (tx_send) begin
        launch_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_launch", {30'b0, grant_id}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_onehot", {28'b0, ack}, 32'(1) << e.id);
          check("grant_id", {30'b0, grant_id}, 32'(e.id));
          check("tx_data", {24'b0, tx_data}, {24'b0, e.data});
          check("busy_at_launch", {31'b0, busy}, 32'd1);
        end
        last_data = tx_data;
      end else if (busy) begin
        check("tx_data_hold", {24'b0, tx_data}, {24'b0, last_data});
      end
    end
  end

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_launch(output int t);
    t = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx_send) begin
        t = cyc;
        return;
      end
    end
    check("launch_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t, prev, bcnt;
    logic [7:0] bytes [4];

    rst = 1'b0;
    req = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {28'b0, ack}, 32'd0);
    check("rst_tx_send", {31'b0, tx_send}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_grant_id", {30'b0, grant_id}, 32'd0);
    rst = 1'b1;

    // First grant after reset, then reset asserted mid-HOLD.
    req = 4'b0010;
    data_in = 32'h0000_1100;
    push_exp(1, 8'h11);
    wait_launch(t);
    req = '0;
    repeat (10) @(negedge clk);
    check("hold_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_ack", {28'b0, ack}, 32'd0);
    check("midrst_tx_send", {31'b0, tx_send}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_tx_data", {24'b0, tx_data}, 32'd0);
    check("midrst_grant_id", {30'b0, grant_id}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester with HOLD-only request pulses that must be ignored.
    req = 4'b0100;
    data_in = 32'h00A5_0000;
    push_exp(2, 8'hA5);
    wait_launch(t);
    req = '0;
    bcnt = 1;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("send_width", {31'b0, tx_send}, 32'd0);
        check("ack_width", {28'b0, ack}, 32'd0);
      end
      if (k == 5) req = 4'b1111;
      if (k == 8) req = '0;
      if (!busy) break;
      bcnt++;
    end
    check("busy_len_single", 32'(bcnt), 32'(L));
    repeat (10) @(negedge clk);
    check("no_launch_hold_pulse", 32'(launch_cnt), 32'd2);

    // Withdraw: req[3] raised and dropped inside HOLD is never captured.
    req = 4'b0001;
    data_in = 32'hEE00_005A;
    push_exp(0, 8'h5A);
    wait_launch(t);
    req = '0;
    bcnt = 1;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (k == 3) req = 4'b1000;
      if (k == 30) req = '0;
      if (!busy) break;
      bcnt++;
    end
    check("busy_len_withdraw", 32'(bcnt), 32'(L));
    repeat (10) @(negedge clk);
    check("no_launch_withdraw", 32'(launch_cnt), 32'd3);

    // Contention from a fresh pointer: order 0,1,2,3,0 at L+1 spacing.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bytes[0] = 8'hB0; bytes[1] = 8'hC1; bytes[2] = 8'hD2; bytes[3] = 8'hE3;
    data_in = {bytes[3], bytes[2], bytes[1], bytes[0]};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) push_exp(n % 4, bytes[n % 4]);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_launch(t);
      if (n > 0) check("launch_spacing", 32'(t - prev), 32'(L + 1));
      prev = t;
    end
    req = '0;
    repeat (L + 20) @(negedge clk);
    check("launch_total", 32'(launch_cnt), 32'd8);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
